cmd_dispatcher: RTL and testbench

Parametrised successor of the single-target PC command interface: pops 36-bit commands from the USB command FIFO, routes register writes/reads to one of `N_TGT` target blocks, and waits on a per-target busy line after a start write. It returns read data and error words to the PC through an external response FIFO write port, with backpressure honoured. It sits between the USB command/response FIFOs and the test-block register banks.

---
 rtl/cmd_dispatcher.sv | 198 +++++++++++++++++++
 tb/tb_cmd_dispatcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: pops PC commands, strobes one of N_TGT register banks,
// waits on read-valid / busy handshakes and pushes read data or error words back.
module cmd_dispatcher #(
  parameter int         N_TGT        = 4,
  parameter logic [7:0] START_OFFS   = 8'h80,
  parameter int         RD_TIMEOUT   = 16,
  parameter int         BUSY_TIMEOUT = 1_000_000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [35:0]         CMD_FIFO_Q,
  input  logic                CMD_FIFO_EMPTY,
  output logic                CMD_FIFO_RDREQ,
  output logic [35:0]         RSP_FIFO_D,
  output logic                RSP_FIFO_WRREQ,
  input  logic                RSP_FIFO_FULL,
  output logic [7:0]          REG_ADDR,
  output logic [15:0]         REG_WDATA,
  output logic [N_TGT-1:0]    REG_WREN,
  output logic [N_TGT-1:0]    REG_RDEN,
  input  logic [16*N_TGT-1:0] REG_RDATA,
  input  logic [N_TGT-1:0]    REG_RDVALID,
  input  logic [N_TGT-1:0]    BUSY,
  output logic [15:0]         CMD_CNT,
  output logic [7:0]          ERR_CNT
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  // The counter holds cycles already spent waiting, so the last allowed cycle is TIMEOUT-1.
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [15:0] ERR_BAD_TGT = 16'h0001;
  localparam logic [15:0] ERR_RD_TO   = 16'h0002;
  localparam logic [15:0] ERR_BUSY_TO = 16'h0003;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAITCMD  = 3'd1,
    DECODE   = 3'd2,
    EXEC     = 3'd3,
    RD_WAIT  = 3'd4,
    OP_START = 3'd5,
    OP_WAIT  = 3'd6,
    RSP      = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [11:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [35:0]        rsp_q, rsp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        cmd_cnt_q, cmd_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [3:0]         tgt;
  logic               tgt_ok;
  logic [N_TGT-1:0]   sel;
  logic               rdvalid_sel;
  logic               busy_sel;
  logic [15:0]        rdata_sel;
  logic               unused_cmd_bits;

  function automatic logic [35:0] err_word(input logic op, input logic [11:0] addr,
                                           input logic [15:0] code);
    return {4'hE, op, 3'b000, addr, code};
  endfunction

  function automatic logic [35:0] rd_word(input logic [11:0] addr, input logic [15:0] data);
    return {4'h1, 1'b1, 3'b000, addr, data};
  endfunction

  assign unused_cmd_bits = ^{CMD_FIFO_Q[35:32], CMD_FIFO_Q[30:28]};

  assign tgt         = addr_q[11:8];
  assign tgt_ok      = ({28'd0, tgt} < 32'(N_TGT));
  assign sel         = tgt_ok ? (N_TGT'(1) << tgt) : '0;
  assign rdvalid_sel = |(REG_RDVALID & sel);
  assign busy_sel    = |(BUSY & sel);

  always_comb begin
    rdata_sel = '0;
    for (int t = 0; t < N_TGT; t++) begin
      if (sel[t]) rdata_sel = REG_RDATA[16*t +: 16];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      cnt_q     <= '0;
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_q     <= rsp_d;
      cnt_q     <= cnt_d;
      cmd_cnt_q <= cmd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    cmd_cnt_d = cmd_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE:    state_d = WAITCMD;
      WAITCMD: if (!CMD_FIFO_EMPTY) state_d = DECODE;
      DECODE: begin
        op_d      = CMD_FIFO_Q[31];
        addr_d    = CMD_FIFO_Q[27:16];
        wdata_d   = CMD_FIFO_Q[15:0];
        cmd_cnt_d = cmd_cnt_q + 16'd1;
        state_d   = EXEC;
      end
      EXEC: begin
        cnt_d = '0;
        if (!tgt_ok) begin
          rsp_d   = err_word(op_q, addr_q, ERR_BAD_TGT);
          state_d = RSP;
        end else if (op_q) begin
          state_d = RD_WAIT;
        end else if (addr_q[7:0] == START_OFFS) begin
          state_d = OP_START;
        end else begin
          state_d = WAITCMD;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rdvalid_sel) begin
          rsp_d   = rd_word(addr_q, rdata_sel);
          state_d = RSP;
        end else if (cnt_q == RD_LAST) begin
          rsp_d   = err_word(op_q, addr_q, ERR_RD_TO);
          state_d = RSP;
        end
      end
      OP_START: begin
        cnt_d   = '0;
        state_d = OP_WAIT;
      end
      OP_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!busy_sel) begin
          state_d = WAITCMD;
        end else if (cnt_q == BUSY_LAST) begin
          rsp_d   = err_word(op_q, addr_q, ERR_BUSY_TO);
          state_d = RSP;
        end
      end
      RSP: begin
        if (!RSP_FIFO_FULL) begin
          if (rsp_q[35:32] == 4'hE && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = WAITCMD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CMD_FIFO_RDREQ = 1'b0;
    REG_WREN       = '0;
    REG_RDEN       = '0;
    RSP_FIFO_WRREQ = 1'b0;
    case (state_q)
      DECODE: CMD_FIFO_RDREQ = 1'b1;
      EXEC: begin
        if (op_q) REG_RDEN = sel;
        else      REG_WREN = sel;
      end
      RSP:     RSP_FIFO_WRREQ = !RSP_FIFO_FULL;
      default: ;
    endcase
  end

  assign RSP_FIFO_D = rsp_q;
  assign REG_ADDR   = addr_q[7:0];
  assign REG_WDATA  = wdata_q;
  assign CMD_CNT    = cmd_cnt_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: a vector table of single commands plus
// hand-written sequences for start/busy handling, backpressure and reset.
module tb_cmd_dispatcher;

  localparam int N_TGT   = 4;
  localparam int RD_TO   = 16;
  localparam int BUSY_TO = 20;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic [35:0]         CMD_FIFO_Q;
  logic                CMD_FIFO_EMPTY;
  logic                CMD_FIFO_RDREQ;
  logic [35:0]         RSP_FIFO_D;
  logic                RSP_FIFO_WRREQ;
  logic                RSP_FIFO_FULL;
  logic [7:0]          REG_ADDR;
  logic [15:0]         REG_WDATA;
  logic [N_TGT-1:0]    REG_WREN;
  logic [N_TGT-1:0]    REG_RDEN;
  logic [16*N_TGT-1:0] REG_RDATA;
  logic [N_TGT-1:0]    REG_RDVALID;
  logic [N_TGT-1:0]    BUSY;
  logic [15:0]         CMD_CNT;
  logic [7:0]          ERR_CNT;

  cmd_dispatcher #(
    .N_TGT(N_TGT), .START_OFFS(8'h80), .RD_TIMEOUT(RD_TO), .BUSY_TIMEOUT(BUSY_TO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CMD_FIFO_Q(CMD_FIFO_Q), .CMD_FIFO_EMPTY(CMD_FIFO_EMPTY), .CMD_FIFO_RDREQ(CMD_FIFO_RDREQ),
    .RSP_FIFO_D(RSP_FIFO_D), .RSP_FIFO_WRREQ(RSP_FIFO_WRREQ), .RSP_FIFO_FULL(RSP_FIFO_FULL),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WREN(REG_WREN), .REG_RDEN(REG_RDEN),
    .REG_RDATA(REG_RDATA), .REG_RDVALID(REG_RDVALID), .BUSY(BUSY),
    .CMD_CNT(CMD_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cmd = 0;
  int exp_err = 0;
  int push_cnt = 0;
  int wren_cnt = 0;
  int rden_cnt = 0;

  // Strobe pulses counted mid-cycle, where all outputs are settled.
  always @(negedge CLK) begin
    if (RSP_FIFO_WRREQ) push_cnt <= push_cnt + 1;
    if (|REG_WREN)      wren_cnt <= wren_cnt + 1;
    if (|REG_RDEN)      rden_cnt <= rden_cnt + 1;
  end

  typedef struct {
    logic             op;
    logic [3:0]       tgt;
    logic [7:0]       offs;
    logic [15:0]      wdata;
    int               rd_k;
    logic [15:0]      rdata;
    logic [N_TGT-1:0] exp_wren;
    logic [N_TGT-1:0] exp_rden;
    int               exp_lat;
    logic [35:0]      exp_rsp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int p0, w0, r0;
    logic [16*N_TGT-1:0] rd;
    p0 = push_cnt; w0 = wren_cnt; r0 = rden_cnt;
    rd = {N_TGT{16'hDEAD}};
    if (v.tgt < N_TGT) rd[16*v.tgt +: 16] = v.rdata;
    REG_RDATA      = rd;
    CMD_FIFO_Q     = {4'h0, v.op, 3'b000, v.tgt, v.offs, v.wdata};
    CMD_FIFO_EMPTY = 1'b0;
    tick();
    chk("decode_rdreq", CMD_FIFO_RDREQ, 1);
    tick();
    CMD_FIFO_EMPTY = 1'b1;
    exp_cmd++;
    chk("exec_wren", REG_WREN, v.exp_wren);
    chk("exec_rden", REG_RDEN, v.exp_rden);
    chk("reg_addr", REG_ADDR, v.offs);
    chk("reg_wdata", REG_WDATA, v.wdata);
    chk("cmd_cnt", CMD_CNT, exp_cmd);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (RSP_FIFO_WRREQ) begin
        lat = i;
        break;
      end
      REG_RDVALID = (i == v.rd_k && v.tgt < N_TGT) ? (N_TGT'(1) << v.tgt) : '0;
      if (v.exp_lat == 0 && i >= 4) break;
    end
    REG_RDVALID = '0;
    chk("rsp_latency", lat, v.exp_lat);
    if (lat != 0) begin
      chk("rsp_word", RSP_FIFO_D, v.exp_rsp);
      if (v.exp_rsp[35:32] == 4'hE) exp_err++;
      tick();
    end
    chk("err_cnt", ERR_CNT, exp_err);
    chk("push_count", push_cnt - p0, (lat != 0) ? 1 : 0);
    chk("wren_pulses", wren_cnt - w0, (v.exp_wren != '0) ? 1 : 0);
    chk("rden_pulses", rden_cnt - r0, (v.exp_rden != '0) ? 1 : 0);
  endtask

  // Issues a start write and returns in the first OP_WAIT cycle.
  task automatic start_write(input logic [3:0] tgt);
    CMD_FIFO_Q     = {4'h0, 1'b0, 3'b000, tgt, 8'h80, 16'h0000};
    CMD_FIFO_EMPTY = 1'b0;
    tick();
    tick();
    CMD_FIFO_EMPTY = 1'b1;
    exp_cmd++;
    chk("start_wren", REG_WREN, N_TGT'(1) << tgt);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, lat, found;
    vecs[0] = '{1'b0, 4'd2, 8'h05, 16'h1234, 0,  16'h0000, 4'b0100, 4'b0000, 0,  36'h0};
    vecs[1] = '{1'b1, 4'd1, 8'h10, 16'h0000, 2,  16'hBEEF, 4'b0000, 4'b0010, 3,  36'h1_8110_BEEF};
    vecs[2] = '{1'b1, 4'd5, 8'h10, 16'h0000, 1,  16'h0000, 4'b0000, 4'b0000, 1,  36'hE_8510_0001};
    vecs[3] = '{1'b0, 4'd3, 8'h7F, 16'hA5A5, 0,  16'h0000, 4'b1000, 4'b0000, 0,  36'h0};
    vecs[4] = '{1'b1, 4'd0, 8'h00, 16'h0000, 1,  16'h0001, 4'b0000, 4'b0001, 2,  36'h1_8000_0001};
    vecs[5] = '{1'b1, 4'd3, 8'hFF, 16'h0000, 16, 16'h5A5A, 4'b0000, 4'b1000, 17, 36'h1_83FF_5A5A};
    vecs[6] = '{1'b1, 4'd2, 8'h20, 16'h0000, 0,  16'h0000, 4'b0000, 4'b0100, 17, 36'hE_8220_0002};
    vecs[7] = '{1'b0, 4'd7, 8'h01, 16'h4321, 0,  16'h0000, 4'b0000, 4'b0000, 1,  36'hE_0701_0001};

    RESET_N        = 1'b0;
    CMD_FIFO_Q     = '0;
    CMD_FIFO_EMPTY = 1'b1;
    RSP_FIFO_FULL  = 1'b0;
    REG_RDATA      = '0;
    REG_RDVALID    = '0;
    BUSY           = '0;
    repeat (3) tick();
    chk("rst_rdreq", CMD_FIFO_RDREQ, 0);
    chk("rst_wrreq", RSP_FIFO_WRREQ, 0);
    chk("rst_wren", REG_WREN, 0);
    chk("rst_rden", REG_RDEN, 0);
    chk("rst_rsp_d", RSP_FIFO_D, 0);
    chk("rst_addr", REG_ADDR, 0);
    chk("rst_wdata", REG_WDATA, 0);
    chk("rst_cmd_cnt", CMD_CNT, 0);
    chk("rst_err_cnt", ERR_CNT, 0);
    RESET_N = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start write; pop of the queued command waits for the selected BUSY to drop.
    p0   = push_cnt;
    BUSY = 4'b0011;
    start_write(4'd0);
    CMD_FIFO_Q     = {4'h0, 1'b0, 3'b000, 4'd1, 8'h01, 16'h0F0F};
    CMD_FIFO_EMPTY = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      chk("busy_hold_rdreq", CMD_FIFO_RDREQ, 0);
      tick();
    end
    BUSY = 4'b0010;
    chk("busy_fall_rdreq", CMD_FIFO_RDREQ, 0);
    tick();
    chk("waitcmd_rdreq", CMD_FIFO_RDREQ, 0);
    tick();
    chk("pop_after_busy", CMD_FIFO_RDREQ, 1);
    tick();
    CMD_FIFO_EMPTY = 1'b1;
    exp_cmd++;
    chk("next_wren", REG_WREN, 4'b0010);
    chk("next_wdata", REG_WDATA, 16'h0F0F);
    chk("next_cmd_cnt", CMD_CNT, exp_cmd);
    tick();
    BUSY = '0;
    chk("busy_ok_no_push", push_cnt - p0, 0);

    // BUSY falling in the very cycle the timeout is reached counts as success.
    BUSY = 4'b0001;
    start_write(4'd0);
    repeat (BUSY_TO - 1) tick();
    BUSY = '0;
    tick();
    chk("busy_edge_wrreq", RSP_FIFO_WRREQ, 0);
    tick();
    chk("busy_edge_err_cnt", ERR_CNT, exp_err);
    chk("busy_edge_no_push", push_cnt - p0, 0);

    // BUSY stuck high: timeout error response.
    BUSY = 4'b0001;
    start_write(4'd0);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (RSP_FIFO_WRREQ) begin
        lat = i;
        break;
      end
    end
    chk("busy_to_latency", lat, BUSY_TO);
    chk("busy_to_word", RSP_FIFO_D, 36'hE_0080_0003);
    chk("busy_to_err_pre", ERR_CNT, exp_err);
    tick();
    exp_err++;
    chk("busy_to_err_cnt", ERR_CNT, exp_err);
    BUSY = '0;

    // Read response held off by a full response FIFO for 10 cycles.
    RSP_FIFO_FULL  = 1'b1;
    REG_RDATA      = {16'hDEAD, 16'hDEAD, 16'h1357, 16'hDEAD};
    CMD_FIFO_Q     = {4'h0, 1'b1, 3'b000, 4'd1, 8'h10, 16'h0000};
    CMD_FIFO_EMPTY = 1'b0;
    tick();
    tick();
    exp_cmd++;
    CMD_FIFO_Q = {4'h0, 1'b0, 3'b000, 4'd3, 8'h02, 16'h0002};
    chk("full_rden", REG_RDEN, 4'b0010);
    tick();
    REG_RDVALID = 4'b0010;
    tick();
    REG_RDVALID = '0;
    p0 = push_cnt;
    for (int c = 0; c < 10; c++) begin
      chk("full_wrreq", RSP_FIFO_WRREQ, 0);
      chk("full_rdreq", CMD_FIFO_RDREQ, 0);
      tick();
    end
    RSP_FIFO_FULL = 1'b0;
    #1;
    chk("nonfull_wrreq", RSP_FIFO_WRREQ, 1);
    chk("nonfull_word", RSP_FIFO_D, 36'h1_8110_1357);
    tick();
    chk("full_push_once", push_cnt - p0, 1);
    chk("after_rsp_rdreq", CMD_FIFO_RDREQ, 0);
    tick();
    chk("after_rsp_pop", CMD_FIFO_RDREQ, 1);
    tick();
    CMD_FIFO_EMPTY = 1'b1;
    exp_cmd++;
    chk("after_rsp_wren", REG_WREN, 4'b1000);
    chk("after_rsp_cmd_cnt", CMD_CNT, exp_cmd);
    tick();

    // Reset asserted mid-cycle during OP_WAIT with another command queued.
    BUSY = 4'b0100;
    start_write(4'd2);
    tick();
    p0 = push_cnt;
    CMD_FIFO_Q     = {4'h0, 1'b0, 3'b000, 4'd2, 8'h03, 16'h00AA};
    CMD_FIFO_EMPTY = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_rdreq", CMD_FIFO_RDREQ, 0);
    chk("arst_wrreq", RSP_FIFO_WRREQ, 0);
    chk("arst_wren", REG_WREN, 0);
    chk("arst_rden", REG_RDEN, 0);
    chk("arst_rsp_d", RSP_FIFO_D, 0);
    chk("arst_addr", REG_ADDR, 0);
    chk("arst_wdata", REG_WDATA, 0);
    chk("arst_cmd_cnt", CMD_CNT, 0);
    chk("arst_err_cnt", ERR_CNT, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    BUSY    = '0;
    exp_cmd = 0;
    exp_err = 0;
    found   = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (CMD_FIFO_RDREQ) begin
        found = i;
        break;
      end
    end
    chk("post_rst_pop_cycle", found, 2);
    tick();
    CMD_FIFO_EMPTY = 1'b1;
    exp_cmd++;
    chk("post_rst_wren", REG_WREN, 4'b0100);
    chk("post_rst_addr", REG_ADDR, 8'h03);
    chk("post_rst_wdata", REG_WDATA, 16'h00AA);
    chk("post_rst_cmd_cnt", CMD_CNT, exp_cmd);
    tick();
    tick();
    chk("post_rst_no_push", push_cnt - p0, 0);
    chk("post_rst_err_cnt", ERR_CNT, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
